// File: rtl/ram_sized_if.sv
// Load/store request and completion bundle between the CPU memory stage and ram_sized.
// The master drives the request fields; the slave returns ready/done/err and the read value.
interface ram_sized_if;
    logic [1:0]  i_do;
    logic [1:0]  i_size;
    logic        i_signed;
    logic [31:0] i_addr;
    logic [31:0] i_val;
    logic [31:0] o_val;
    logic        o_ready;
    logic        o_done;
    logic        o_err;

    modport master (
        output i_do, i_size, i_signed, i_addr, i_val,
        input  o_val, o_ready, o_done, o_err
    );

    modport slave (
        input  i_do, i_size, i_signed, i_addr, i_val,
        output o_val, o_ready, o_done, o_err
    );
endinterface

// File: rtl/ram_sized.sv
// Byte-addressed big-endian RAM with byte/halfword/word access, extension and error reporting.
// Latency: request accepted at edge N executes at edge N+LATENCY; o_done pulses the cycle after.
// Backpressure: o_ready is low while BUSY; requests presented then are ignored until IDLE.
module ram_sized #(
    parameter int MEM_SIZE = 4096,
    parameter int LATENCY  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    ram_sized_if.slave bus
);
    localparam int             AW       = $clog2(MEM_SIZE);
    localparam int             CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]  CNT_INIT = CW'(LATENCY - 1);
    localparam logic [32:0]    MEM_LIM  = 33'(MEM_SIZE);
    localparam logic [1:0]     OP_READ  = 2'b01;
    localparam logic [1:0]     OP_WRITE = 2'b10;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [1:0]  req_do;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_val;
    logic [31:0] val_q;
    logic        ready_q;
    logic        done_q;
    logic        err_q;

    logic [7:0]  mem [MEM_SIZE];

    logic [2:0]    nbytes;
    logic          req_err;
    logic          exec;
    logic          sx;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   rd_data;

    always_comb begin
        nbytes = 3'd0;
        case (req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            2'b10:   nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
    end

    // Range check is done in 33 bits so addresses near 2^32 cannot wrap into range.
    assign req_err = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (({1'b0, req_addr} + 33'(nbytes)) > MEM_LIM);

    assign exec = (state == BUSY) && (cnt == '0);

    assign a0 = req_addr[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    // Big-endian: the first byte always carries the data MSB, whatever the size.
    assign sx = req_signed & b0[7];

    always_comb begin
        rd_data = 32'h0;
        case (req_size)
            2'b00:   rd_data = {{24{sx}}, b0};
            2'b01:   rd_data = {{16{sx}}, b0, b1};
            2'b10:   rd_data = {b0, b1, b2, b3};
            default: rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_do     <= 2'b00;
            req_size   <= 2'b00;
            req_signed <= 1'b0;
            req_addr   <= 32'h0;
            req_val    <= 32'h0;
            val_q      <= 32'h0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_do == OP_READ || bus.i_do == OP_WRITE) begin
                        req_do     <= bus.i_do;
                        req_size   <= bus.i_size;
                        req_signed <= bus.i_signed;
                        req_addr   <= bus.i_addr;
                        req_val    <= bus.i_val;
                        cnt        <= CNT_INIT;
                        state      <= BUSY;
                        ready_q    <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        done_q  <= 1'b1;
                        err_q   <= req_err;
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        if (req_err)
                            val_q <= 32'h0;
                        else if (req_do == OP_READ)
                            val_q <= rd_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is not reset; a reset coinciding with execution suppresses the write.
    always_ff @(posedge i_clk) begin
        if (exec && !i_rst && req_do == OP_WRITE && !req_err) begin
            case (req_size)
                2'b00: mem[a0] <= req_val[7:0];
                2'b01: begin
                    mem[a0] <= req_val[15:8];
                    mem[a1] <= req_val[7:0];
                end
                2'b10: begin
                    mem[a0] <= req_val[31:24];
                    mem[a1] <= req_val[23:16];
                    mem[a2] <= req_val[15:8];
                    mem[a3] <= req_val[7:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.o_val   = val_q;
    assign bus.o_ready = ready_q;
    assign bus.o_done  = done_q;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_ram_sized.sv
// Bench for ram_sized (LATENCY=3): directed table, handshake/reset sequences, and random ops
// checked against a byte-array reference model.
module tb_ram_sized;
    localparam int MEM_SIZE = 4096;
    localparam int LAT      = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_sized_if bus ();

    ram_sized #(.MEM_SIZE(MEM_SIZE), .LATENCY(LAT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  d;
        logic [1:0]  s;
        logic        sg;
        logic [31:0] a;
        logic [31:0] v;
        logic [31:0] ev;
        logic        ee;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mdl   [MEM_SIZE];
    bit          known [MEM_SIZE];
    logic [31:0] last_val = 32'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: works on whole byte lists and integer arithmetic, not on the RTL structure.
    task automatic model_op(input logic [1:0] d, input logic [1:0] s, input logic sg,
                            input logic [31:0] a, input logic [31:0] v,
                            output logic [31:0] ev, output logic ee, output logic vchk);
        int     nb;
        int     idx;
        longint acc;
        nb   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
        ee   = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00)
            || (longint'(a) + longint'(nb) > longint'(MEM_SIZE));
        vchk = 1'b1;
        ev   = last_val;
        if (ee) begin
            ev = 32'h0;
            last_val = 32'h0;
        end else if (d == 2'b01) begin
            acc = 0;
            for (int i = 0; i < nb; i++) begin
                idx = int'(a) + i;
                if (!known[idx]) vchk = 1'b0;
                acc = (acc << 8) | longint'(mdl[idx]);
            end
            if (sg && acc[8*nb-1]) acc = acc - (longint'(1) << (8*nb));
            ev = acc[31:0];
            last_val = ev;
        end else begin
            for (int i = 0; i < nb; i++) begin
                idx = int'(a) + i;
                mdl[idx]   = 8'(v >> (8*(nb-1-i)));
                known[idx] = 1'b1;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] d, input logic [1:0] s,
                         input logic sg, input logic [31:0] a, input logic [31:0] v,
                         output logic [31:0] rv, output logic re);
        int   guard;
        int   lat;
        logic rdy_bad;
        guard = 0;
        while (bus.o_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.i_do = d; bus.i_size = s; bus.i_signed = sg; bus.i_addr = a; bus.i_val = v;
        @(posedge clk); #1;
        check({tag, " ready_after_accept"}, 32'(bus.o_ready), 32'h0);
        // Junk on the inputs while BUSY must be ignored.
        bus.i_do     = 2'($urandom_range(1, 2));
        bus.i_size   = 2'($urandom);
        bus.i_signed = 1'($urandom);
        bus.i_addr   = $urandom;
        bus.i_val    = $urandom;
        lat = 0;
        rdy_bad = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (bus.o_done !== 1'b1 && bus.o_ready === 1'b1) rdy_bad = 1'b1;
        end while (bus.o_done !== 1'b1 && lat < 100);
        bus.i_do = 2'b00;
        check({tag, " latency"}, 32'(lat), 32'(LAT));
        check({tag, " ready_low_while_busy"}, 32'(rdy_bad), 32'h0);
        rv = bus.o_val;
        re = bus.o_err;
        @(posedge clk); #1;
        check({tag, " done_pulse_width"}, 32'(bus.o_done), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [19];
        logic [31:0] rv, ev;
        logic        re, ee, vchk;
        int          lat, lat2;
        logic        bad;
        logic [1:0]  d, s;
        logic        sg;
        logic [31:0] a, v;
        int          r;

        vt[0]  = '{2'b10, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
        vt[1]  = '{2'b01, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{2'b01, 2'b00, 1'b0, 32'h10, 32'h0, 32'h000000DE, 1'b0};
        vt[3]  = '{2'b01, 2'b00, 1'b0, 32'h13, 32'h0, 32'h000000EF, 1'b0};
        vt[4]  = '{2'b10, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55, 32'h000000EF, 1'b0};
        vt[5]  = '{2'b01, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0};
        vt[6]  = '{2'b10, 2'b01, 1'b0, 32'h20, 32'h12348001, 32'hDE55BEEF, 1'b0};
        vt[7]  = '{2'b01, 2'b01, 1'b1, 32'h20, 32'h0, 32'hFFFF8001, 1'b0};
        vt[8]  = '{2'b01, 2'b01, 1'b0, 32'h20, 32'h0, 32'h00008001, 1'b0};
        vt[9]  = '{2'b01, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1};
        vt[10] = '{2'b10, 2'b01, 1'b0, 32'(MEM_SIZE-2), 32'h00001234, 32'h0, 1'b0};
        vt[11] = '{2'b10, 2'b10, 1'b0, 32'(MEM_SIZE-2), 32'hAABBCCDD, 32'h0, 1'b1};
        vt[12] = '{2'b01, 2'b01, 1'b0, 32'(MEM_SIZE-2), 32'h0, 32'h00001234, 1'b0};
        vt[13] = '{2'b01, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1};
        vt[14] = '{2'b01, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFFEF, 1'b0};
        vt[15] = '{2'b10, 2'b11, 1'b0, 32'h30, 32'h01020304, 32'h0, 1'b1};
        vt[16] = '{2'b01, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1};
        vt[17] = '{2'b01, 2'b00, 1'b0, 32'(MEM_SIZE-1), 32'h0, 32'h00000034, 1'b0};
        vt[18] = '{2'b01, 2'b00, 1'b0, 32'(MEM_SIZE), 32'h0, 32'h0, 1'b1};

        bus.i_do = 2'b00; bus.i_size = 2'b00; bus.i_signed = 1'b0;
        bus.i_addr = 32'h0; bus.i_val = 32'h0;

        // Reset state
        #12;
        check("reset o_ready", 32'(bus.o_ready), 32'h1);
        check("reset o_done",  32'(bus.o_done),  32'h0);
        check("reset o_err",   32'(bus.o_err),   32'h0);
        check("reset o_val",   bus.o_val,        32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 19; i++) begin
            do_op($sformatf("vec%0d", i), vt[i].d, vt[i].s, vt[i].sg, vt[i].a, vt[i].v, rv, re);
            model_op(vt[i].d, vt[i].s, vt[i].sg, vt[i].a, vt[i].v, ev, ee, vchk);
            check($sformatf("vec%0d o_val", i), rv, vt[i].ev);
            check($sformatf("vec%0d o_err", i), 32'(re), 32'(vt[i].ee));
        end

        // NOP and reserved op while IDLE never complete
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.i_do = (i % 2 == 0) ? 2'b00 : 2'b11;
            bus.i_addr = $urandom;
            @(posedge clk); #1;
            if (bus.o_done !== 1'b0 || bus.o_ready !== 1'b1) bad = 1'b1;
        end
        bus.i_do = 2'b00;
        check("nop idle no effect", 32'(bad), 32'h0);

        // Request held while BUSY is taken at the first IDLE edge
        bus.i_do = 2'b01; bus.i_size = 2'b10; bus.i_signed = 1'b0; bus.i_addr = 32'h10;
        @(posedge clk); #1;
        model_op(2'b01, 2'b10, 1'b0, 32'h10, 32'h0, ev, ee, vchk);
        bus.i_do = 2'b01; bus.i_size = 2'b00; bus.i_signed = 1'b1; bus.i_addr = 32'h10;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (bus.o_done !== 1'b1 && lat < 100);
        check("busy_req first latency", 32'(lat), 32'(LAT));
        check("busy_req first o_val", bus.o_val, ev);
        model_op(2'b01, 2'b00, 1'b1, 32'h10, 32'h0, ev, ee, vchk);
        lat2 = 0;
        do begin
            @(posedge clk); #1;
            lat2++;
            if (lat2 == 1) bus.i_do = 2'b00;
        end while (bus.o_done !== 1'b1 && lat2 < 100);
        check("busy_req second spacing", 32'(lat2), 32'(LAT + 1));
        check("busy_req second o_val", bus.o_val, ev);
        @(posedge clk); #1;

        // Reset one cycle after a write is accepted aborts it
        do_op("rst_pre", 2'b10, 2'b10, 1'b0, 32'h40, 32'h11223344, rv, re);
        model_op(2'b10, 2'b10, 1'b0, 32'h40, 32'h11223344, ev, ee, vchk);
        bus.i_do = 2'b10; bus.i_size = 2'b10; bus.i_addr = 32'h40; bus.i_val = 32'h99999999;
        @(posedge clk); #1;
        bus.i_do = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst o_ready", 32'(bus.o_ready), 32'h1);
        check("midrst o_done",  32'(bus.o_done),  32'h0);
        check("midrst o_val",   bus.o_val,        32'h0);
        last_val = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst held o_done", 32'(bus.o_done), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("rst_post", 2'b01, 2'b10, 1'b0, 32'h40, 32'h0, rv, re);
        model_op(2'b01, 2'b10, 1'b0, 32'h40, 32'h0, ev, ee, vchk);
        check("midrst old contents", rv, 32'h11223344);

        // Fill the random-test region so every read address is known
        for (int k = 0; k < 64; k++) begin
            v = $urandom;
            do_op("fill", 2'b10, 2'b10, 1'b0, 32'(4*k), v, rv, re);
            model_op(2'b10, 2'b10, 1'b0, 32'(4*k), v, ev, ee, vchk);
        end
        v = $urandom;
        do_op("fill_top", 2'b10, 2'b10, 1'b0, 32'(MEM_SIZE-4), v, rv, re);
        model_op(2'b10, 2'b10, 1'b0, 32'(MEM_SIZE-4), v, ev, ee, vchk);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            d  = 2'($urandom_range(1, 2));
            s  = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            v  = $urandom;
            r  = $urandom_range(0, 9);
            if (r < 8)       a = 32'($urandom_range(0, 255));
            else if (r == 8) a = 32'(MEM_SIZE - 4) + 32'($urandom_range(0, 4));
            else             a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            model_op(d, s, sg, a, v, ev, ee, vchk);
            do_op($sformatf("rnd%0d", n), d, s, sg, a, v, rv, re);
            check($sformatf("rnd%0d o_err", n), 32'(re), 32'(ee));
            if (vchk) check($sformatf("rnd%0d o_val", n), rv, ev);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ram_sized.md
Name: ram_sized

Overview:
- Parametrised successor to the core's flat byte RAM: byte-addressed, big-endian storage with byte, halfword and word access sizes.
- Provides a configurable access latency with a ready/done handshake, sign- or zero-extended reads, and misalignment and range error reporting.
- Sits between the CPU load/store stage and memory; the CPU holds a request until it is accepted and waits for done.

Parameters:
- MEM_SIZE, 4096, memory size in bytes (power of two, >= 4).
- LATENCY, 1, cycles from request acceptance to completion (>= 1).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_do  input  2  operation: 00 NOP, 01 READ, 10 WRITE, 11 reserved (treated as NOP).
- i_size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 invalid.
- i_signed  input  1  reads only: 1 sign-extends, 0 zero-extends.
- i_addr  input  32  byte address of the most-significant byte of the access.
- i_val  input  32  write data, right-aligned (byte uses [7:0], halfword uses [15:0]).
- o_val  output  32  read result, right-aligned and extended.
- o_ready  output  1  high when a new request can be accepted.
- o_done  output  1  one-cycle pulse marking completion of the accepted request.
- o_err  output  1  valid with o_done; set when the request was rejected.

Behaviour:
- Reset (async, i_rst=1):
  - State goes to IDLE; o_ready=1, o_done=0, o_err=0, o_val=0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts the request; a pending write is never performed.
- States: IDLE and BUSY. o_ready=1 exactly when the state is IDLE.
- Acceptance:
  - A request is accepted at the rising edge where state=IDLE and i_do is READ or WRITE.
  - At that edge i_do, i_size, i_signed, i_addr and i_val are captured; the state goes to BUSY and a counter loads LATENCY-1.
  - Inputs are ignored while BUSY and may change freely.
- BUSY:
  - At each edge with counter!=0, the counter decrements.
  - At the edge with counter==0, the operation executes: o_done<=1, o_err is set per the error rule, and the state returns to IDLE.
  - o_done deasserts at the next edge.
  - Timing: accepted at edge N, executed at edge N+LATENCY; o_done is high for the cycle after that edge. The next request can be accepted at edge N+LATENCY+1, so peak throughput is one access per LATENCY+1 cycles.
- Byte order (big-endian): mem[a] is the most-significant byte.
  - Word = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  - Halfword = {mem[a], mem[a+1]}.
- Reads:
  - o_val = the data right-aligned; upper bits are filled with the data MSB if i_signed=1, else with 0.
  - o_val holds its value until the next completion.
- Writes:
  - Only the addressed bytes change, taken from the low bits of i_val.
  - o_val is unchanged on a write completion.
- Error rule (evaluated on the captured request):
  - Causes: i_size=11; halfword with addr[0]=1; word with addr[1:0]!=0; or addr + size_bytes > MEM_SIZE. Range is computed without 32-bit wraparound, so addresses near 0xFFFFFFFF are errors.
  - On error: no memory access, o_err=1 with o_done, and o_val=0 (for reads and writes alike).
  - o_err=0 on a successful completion.
- A NOP while IDLE has no effect; o_done stays 0.

Test Plan:
- Word write then read: write 0xDEADBEEF to 0x10, then read word 0x10 -> o_val=0xDEADBEEF; byte read 0x10 -> 0x000000DE; byte read 0x13 -> 0x000000EF.
- Byte write merge: after the word write above, write byte 0x55 to 0x11 -> word read 0x10 = 0xDE55BEEF.
- Extension: store halfword 0x8001 at 0x20; halfword read at 0x20 with i_signed=1 -> 0xFFFF8001, with i_signed=0 -> 0x00008001.
- Errors:
  - Word read at 0x22 -> o_err=1, o_val=0.
  - Word write at MEM_SIZE-2 -> o_err=1, and the following read of MEM_SIZE-2 as a halfword is unchanged.
  - i_size=11 -> o_err=1.
- Latency and handshake, with LATENCY=3:
  - A read accepted at edge N gives o_ready=0 for 3 cycles and o_done for one cycle after edge N+3.
  - A request presented while BUSY is not accepted and is taken at the first IDLE edge.
- Reset mid-write: assert i_rst one cycle after a write to 0x40 is accepted (LATENCY=3) -> o_ready=1 and o_done=0 immediately; a later read of 0x40 returns the old contents.
